// File: rtl/pc_sequencer.sv
// pc_sequencer: Moore FSM sequencing fetch/decode/execute/mem/writeback and driving PC control.
// Ports: clk, Reset (async active-low); imemReady/dmemReady handshakes; condPass, isBranch,
// isPcWrite, isLoad, writesReg, halt, isLink decoded attributes; pcIncr/pcBranch/pcWrite PC
// controls; imemRead, irLoad, dmemRead, regWrite, linkWrite, fault, halted status/strobes.
// MEM_TIMEOUT bounds ready waits in FETCH/MEM (0 disables). Define PC_SEQUENCER_LINK_EN to
// drive linkWrite for taken BL instructions.
module pc_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic Reset,
  input  logic imemReady,
  input  logic dmemReady,
  input  logic condPass,
  input  logic isBranch,
  input  logic isPcWrite,
  input  logic isLoad,
  input  logic writesReg,
  input  logic halt,
  input  logic isLink,
  output logic pcIncr,
  output logic pcBranch,
  output logic pcWrite,
  output logic imemRead,
  output logic irLoad,
  output logic dmemRead,
  output logic regWrite,
  output logic linkWrite,
  output logic fault,
  output logic halted
);
  localparam int CW = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALTED, FAULT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic timed_out, in_wb, take_br, take_pw;
  assign timed_out = (MEM_TIMEOUT != 0) && (wait_q == CW'(MEM_TIMEOUT));
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = imemReady ? DECODE : timed_out ? FAULT : FETCH;
      DECODE:  state_d = EXECUTE;
      EXECUTE: state_d = (isLoad && condPass) ? MEM : WB;
      MEM:     state_d = dmemReady ? WB : timed_out ? FAULT : MEM;
      WB:      state_d = halt ? HALTED : FETCH;
      HALTED:  state_d = halt ? HALTED : FETCH;
      default: state_d = FAULT;
    endcase
    // Counter only runs while parked in a wait state; any transition clears it.
    wait_d = (state_d == state_q && (state_q == FETCH || state_q == MEM)) ? wait_q + 1'b1 : '0;
  end
  // Every output is gated by Reset so nothing leaks while reset is held.
  always_comb begin
    in_wb     = Reset && state_q == WB;
    take_br   = condPass && isBranch;
    take_pw   = condPass && isPcWrite && !take_br;
    imemRead  = Reset && state_q == FETCH;
    irLoad    = imemRead && imemReady;
    dmemRead  = Reset && state_q == MEM;
    regWrite  = in_wb && condPass && writesReg && !isPcWrite;
    pcBranch  = in_wb && take_br;
    pcWrite   = in_wb && take_pw;
    pcIncr    = in_wb && !take_br && !take_pw;
    halted    = Reset && state_q == HALTED;
    fault     = Reset && state_q == FAULT;
`ifdef PC_SEQUENCER_LINK_EN
    linkWrite = in_wb && take_br && isLink;
`else
    linkWrite = 1'b0;
`endif
  end
`ifndef PC_SEQUENCER_LINK_EN
  logic unused_link;
  assign unused_link = isLink;
`endif
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, giving the maximum wait cycles in FETCH or MEM before FAULT; a value of 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have inputs imemReady, dmemReady, 1 bit each: the instruction-memory and data-memory handshakes.
REQ-005 SHALL have inputs condPass, isBranch, isPcWrite, isLoad, writesReg, halt, 1 bit each: decoded instruction attributes and the halt request.
REQ-006 SHALL have input isLink, 1 bit: the BL indicator, used only under LINK_EN.
REQ-007 SHALL have outputs pcIncr, pcBranch, pcWrite, 1 bit each: drive the program counter's incrEnable, Branch and writeEnable.
REQ-008 SHALL have outputs imemRead, irLoad, dmemRead, regWrite, linkWrite, fault, halted, 1 bit each.

Function
REQ-009 SHALL implement a Moore FSM with states FETCH, DECODE, EXECUTE, MEM, WB, HALTED and FAULT; outputs decode from state, qualified by inputs only where stated.
REQ-010 FETCH: imemRead=1; when imemReady=1, irLoad=1 for that cycle, and the next state is DECODE; otherwise stay in FETCH.
REQ-011 DECODE: lasts one cycle, then EXECUTE; no outputs asserted.
REQ-012 EXECUTE: if isLoad & condPass, the next state is MEM; otherwise WB.
REQ-013 MEM: dmemRead=1; when dmemReady=1, the next state is WB; otherwise stay in MEM.
REQ-014 WB: regWrite = condPass & writesReg & ~isPcWrite.
REQ-015 WB PC select (priority order): condPass & isBranch gives pcBranch=1; else condPass & isPcWrite gives pcWrite=1; else pcIncr=1.
REQ-016 At most one of pcIncr/pcBranch/pcWrite SHALL be 1 in any cycle, and only in WB; PC changes exactly once per instruction.
REQ-017 WB exit: if halt=1, the next state is HALTED; else FETCH.
REQ-018 HALTED: halted=1; stay while halt=1; return to FETCH in the cycle after halt is sampled 0.
REQ-019 Timeout: a 4-bit-minimum wait counter is cleared on entry to FETCH or MEM and increments each cycle the corresponding ready signal is low.
REQ-020 If the wait counter equals MEM_TIMEOUT (nonzero) with ready still low, the next state is FAULT; a ready arriving in that same cycle wins and is taken normally.
REQ-021 FAULT: fault=1, all other outputs 0; sticky until Reset.
REQ-022 Minimum instruction latency, with ready=1 in the first cycle: 4 cycles non-load (FETCH, DECODE, EXECUTE, WB); 5 cycles load.

Reset
REQ-023 While Reset=0, the state SHALL be forced to FETCH, the wait counter to 0, and all outputs to 0 (gated), including imemRead.
REQ-024 Reset assertion mid-instruction SHALL abort immediately with no PC control pulse; after release, fetching begins in FETCH in the first clock.

Configuration
REQ-025 Macro PC_SEQUENCER_LINK_EN defined: in WB, linkWrite = condPass & isBranch & isLink, asserted in the same cycle as pcBranch.
REQ-026 Macro PC_SEQUENCER_LINK_EN undefined: linkWrite is tied 0, isLink is ignored, and all other behaviour is identical.

Verification
REQ-027 Reset low 3 cycles, then high, with imemReady=1, no branch -> imemRead=1 from the first cycle after release; pcIncr pulses every 4th cycle; pcBranch=pcWrite=0.
REQ-028 isBranch=1, condPass=1 -> pcBranch=1 for one cycle in WB, pcIncr=0; with condPass=0 -> pcIncr=1 instead.
REQ-029 isLoad=1, condPass=1, dmemReady low 3 cycles -> dmemRead high 4 cycles; regWrite and pcIncr in WB at cycle 8 from FETCH.
REQ-030 MEM_TIMEOUT=15, imemReady held 0 -> fault=1 after 16 FETCH cycles and stays 1; fault clears only on Reset.
REQ-031 halt=1 during WB -> halted=1; deassert halt -> FETCH next cycle, no extra pcIncr.
REQ-032 LINK_EN build, BL with condPass=1 -> linkWrite=1 and pcBranch=1 in the same cycle; non-LINK_EN build -> linkWrite stays 0.
